// File: rtl/pipeline_scoreboard_pkg.sv
// ============================================================================
// Module   : pipeline_scoreboard_pkg
// Purpose  : Shared latency classes and forward-select encoding for the core.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_scoreboard_pkg;

  localparam int unsigned LAT_ALU     = 1;
  localparam int unsigned LAT_LOAD    = 2;
  localparam int unsigned FWD_REGFILE = 0;

endpackage

`default_nettype wire

// File: rtl/sb_entry.sv
// ============================================================================
// Module   : sb_entry
// Purpose  : Pending/remaining-latency/age tracker for one architectural register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sb_entry
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned KILL_AGE = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           set,
  input  logic                           redirect,
  input  logic [$clog2(MAX_LAT+1)-1:0]   lat,
  output logic                           pending,
  output logic [$clog2(MAX_LAT+1)-1:0]   remain,
  output logic [$clog2(DEPTH+1)-1:0]     age
);

  localparam int unsigned RW = $clog2(MAX_LAT + 1);
  localparam int unsigned AW = $clog2(DEPTH + 1);

  logic          r_pending;
  logic [RW-1:0] r_remain;
  logic [AW-1:0] r_age;
  logic [RW-1:0] w_lat_eff;
  logic          w_kill;
  logic          w_expire;

  // A zero latency is meaningless for a producer; fold it onto the ALU class.
  assign w_lat_eff = (lat == '0) ? RW'(LAT_ALU) : lat;
  assign w_kill    = redirect && (32'(r_age) < KILL_AGE);
  assign w_expire  = 32'(r_age) >= DEPTH;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_remain  <= '0;
      r_age     <= '0;
    end else if (set) begin
      r_pending <= 1'b1;
      r_remain  <= w_lat_eff - RW'(1);
      r_age     <= AW'(1);
    end else if (r_pending) begin
      if (w_kill || w_expire) begin
        r_pending <= 1'b0;
        r_remain  <= '0;
        r_age     <= '0;
      end else begin
        r_age <= r_age + AW'(1);
        if (r_remain != '0) begin
          r_remain <= r_remain - RW'(1);
        end
      end
    end
  end

  assign pending = r_pending;
  assign remain  = r_remain;
  assign age     = r_age;

endmodule

`default_nettype wire

// File: rtl/pipeline_scoreboard.sv
// ============================================================================
// Module   : pipeline_scoreboard
// Purpose  : Issue-stage hazard scoreboard producing stall and forward selects.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_scoreboard
  import pipeline_scoreboard_pkg::*;
#(
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned DEPTH    = 3,
  parameter int unsigned MAX_LAT  = 4,
  parameter int unsigned KILL_AGE = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          issue_valid,
  input  logic                          issue_rd_we,
  input  logic [$clog2(NUM_REGS)-1:0]   issue_rd,
  input  logic [$clog2(MAX_LAT+1)-1:0]  issue_lat,
  input  logic [$clog2(NUM_REGS)-1:0]   issue_rs1,
  input  logic [$clog2(NUM_REGS)-1:0]   issue_rs2,
  input  logic                          uses_rs1,
  input  logic                          uses_rs2,
  input  logic                          redirect,
  output logic                          stall,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_rs1,
  output logic [$clog2(DEPTH+1)-1:0]    fwd_sel_rs2,
  output logic                          issue_fire
);

  localparam int unsigned IW = $clog2(NUM_REGS);
  localparam int unsigned RW = $clog2(MAX_LAT + 1);
  localparam int unsigned AW = $clog2(DEPTH + 1);

  logic          w_pending [NUM_REGS];
  logic [RW-1:0] w_remain  [NUM_REGS];
  logic [AW-1:0] w_age     [NUM_REGS];

  logic w_rs1_pend, w_rs1_ready, w_rs1_hazard;
  logic w_rs2_pend, w_rs2_ready, w_rs2_hazard;

  // x0 is never written, so its slot is a constant "not pending".
  assign w_pending[0] = 1'b0;
  assign w_remain[0]  = '0;
  assign w_age[0]     = '0;

  generate
    for (genvar i = 1; i < NUM_REGS; i++) begin : g_entry
      sb_entry #(
        .DEPTH    (DEPTH),
        .MAX_LAT  (MAX_LAT),
        .KILL_AGE (KILL_AGE)
      ) u_entry (
        .clk      (clk),
        .rst_n    (rst_n),
        .set      (issue_fire && issue_rd_we && (issue_rd == IW'(i))),
        .redirect (redirect),
        .lat      (issue_lat),
        .pending  (w_pending[i]),
        .remain   (w_remain[i]),
        .age      (w_age[i])
      );
    end
  endgenerate

  always_comb begin
    w_rs1_pend   = w_pending[issue_rs1] && (issue_rs1 != '0);
    w_rs2_pend   = w_pending[issue_rs2] && (issue_rs2 != '0);
    w_rs1_ready  = w_rs1_pend && (w_remain[issue_rs1] == '0);
    w_rs2_ready  = w_rs2_pend && (w_remain[issue_rs2] == '0);
    w_rs1_hazard = uses_rs1 && w_rs1_pend && !w_rs1_ready;
    w_rs2_hazard = uses_rs2 && w_rs2_pend && !w_rs2_ready;

    stall       = issue_valid && (w_rs1_hazard || w_rs2_hazard);
    // Forward distance is the producer's age: the stage it currently sits in.
    fwd_sel_rs1 = w_rs1_ready ? w_age[issue_rs1] : AW'(FWD_REGFILE);
    fwd_sel_rs2 = w_rs2_ready ? w_age[issue_rs2] : AW'(FWD_REGFILE);
    issue_fire  = issue_valid && !stall && !redirect;
  end

endmodule

`default_nettype wire
